demux1_2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer. It is the receive-side counterpart of the 2:1 mux: one input stream is steered to one of two output channels.
- Steering is per packet. `sel` is sampled on the first beat of a packet, and the route is held until the beat carrying `in_last` is accepted.
- Each output has a one-entry holding register with a valid/ready handshake.
- Per-channel packet counters support monitoring.

---
 rtl/demux1_2_stream.sv | 117 +++++++++++
 tb/tb_demux1_2_stream.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_stream.sv
// Registered 1:2 stream demux with per-packet routing.
// Each output has a one-entry holding register and a packet counter.
module demux1_2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ROUTE0,
    ROUTE1
  } state_t;

  state_t state, state_nx;

  logic target;
  logic accept;
  logic free0, free1;
  logic load0, load1;
  logic drain0, drain1;

  assign free0  = !out0_valid || out0_ready;
  assign free1  = !out1_valid || out1_ready;
  assign drain0 = out0_valid && out0_ready;
  assign drain1 = out1_valid && out1_ready;

  always_comb begin
    target   = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE:    target = sel;
      ROUTE0:  target = 1'b0;
      ROUTE1:  target = 1'b1;
      default: target = 1'b0;
    endcase
    // rst_n gates in_ready so nothing is offered while held in reset
    in_ready = rst_n && (target ? free1 : free0);
    accept   = in_valid && in_ready;
    load0    = accept && !target;
    load1    = accept && target;
    if (accept) begin
      if (in_last)
        state_nx = IDLE;
      else if (state == IDLE)
        state_nx = sel ? ROUTE1 : ROUTE0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
      out0_last  <= 1'b0;
    end else if (load0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
      out0_last  <= in_last;
    end else if (drain0) begin
      out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out1_last  <= 1'b0;
    end else if (load1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
      out1_last  <= in_last;
    end else if (drain1) begin
      out1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (drain0 && out0_last)
        cnt0 <= cnt0 + CNT_W'(1);
      if (drain1 && out1_last)
        cnt1 <= cnt1 + CNT_W'(1);
    end
  end

  assign busy = (state != IDLE) || out0_valid || out1_valid;

endmodule

// File: tb/tb_demux1_2_stream.sv
// Directed bench for demux1_2_stream with per-channel
// scoreboard queues checked by an independent monitor.
module tb_demux1_2_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] q0[$];
  logic [WIDTH:0] q1[$];

  demux1_2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .sel        (sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake is seen at the negedge before the edge that takes it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL out0_unexpected: got %0h want none",
                   {out0_last, out0_data});
        end else begin
          logic [WIDTH:0] e;
          e = q0.pop_front();
          if ({out0_last, out0_data} !== e) begin
            errors++;
            $display("FAIL out0_beat: got %0h want %0h",
                     {out0_last, out0_data}, e);
          end
        end
      end
      if (out1_valid && out1_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL out1_unexpected: got %0h want none",
                   {out1_last, out1_data});
        end else begin
          logic [WIDTH:0] e;
          e = q1.pop_front();
          if ({out1_last, out1_data} !== e) begin
            errors++;
            $display("FAIL out1_beat: got %0h want %0h",
                     {out1_last, out1_data}, e);
          end
        end
      end
    end
  end

  // Drive one beat; expected channel is given by the caller.
  task automatic send(input logic [WIDTH-1:0] d, input logic l,
                      input logic s, input int ch, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    sel      = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 want in_ready=1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (ch == 0) q0.push_back({l, d});
      else         q1.push_back({l, d});
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int w;
  logic [CNT_W-1:0] wrap_exp[5];
  bit hold_ok;

  initial begin
    // Reset with in_valid high
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_data    = 8'hA5;
    in_last    = 1'b1;
    sel        = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valids", {out1_valid, out0_valid}, 0);
    chk("rst_lasts", {out1_last, out0_last}, 0);
    chk("rst_data", {out1_data, out0_data}, 0);
    chk("rst_cnts", {cnt1, cnt0}, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'hA5, 1'b1, 1'b0, 0, w);
    chk("first_accept_wait", w, 0);
    chk("first_out0_valid", out0_valid, 1);

    // 3-beat packet to ch0 with sel toggling
    do_reset();
    send(8'hA1, 1'b0, 1'b0, 0, w);
    send(8'hA2, 1'b0, 1'b1, 0, w);
    send(8'hA3, 1'b1, 1'b0, 0, w);
    chk("pkt3_busy_holding", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("pkt3_cnt0", cnt0, 1);
    chk("pkt3_cnt1", cnt1, 0);
    chk("pkt3_idle", busy, 0);

    // Back-to-back single-beat packets
    do_reset();
    send(8'h11, 1'b1, 1'b1, 1, w);
    chk("b2b_out1_valid", out1_valid, 1);
    send(8'h22, 1'b1, 1'b0, 0, w);
    chk("b2b_no_bubble", w, 0);
    chk("b2b_out0_valid", out0_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_cnts", {cnt1, cnt0}, {2'd1, 2'd1});

    // Channel 0 stall
    do_reset();
    out0_ready = 1'b0;
    send(8'hB1, 1'b0, 1'b0, 0, w);
    in_valid = 1'b1;
    in_data  = 8'hB2;
    in_last  = 1'b0;
    sel      = 1'b1;
    hold_ok  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out0_valid !== 1'b1 || out0_data !== 8'hB1)
        hold_ok = 1'b0;
    end
    chk("stall_hold", hold_ok, 1);
    chk("stall_busy", busy, 1);
    @(posedge clk);
    #1;
    out0_ready = 1'b1;
    send(8'hB2, 1'b0, 1'b1, 0, w);
    chk("stall_resume_b2", w, 0);
    send(8'hB3, 1'b1, 1'b1, 0, w);
    chk("stall_resume_b3", w, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_cnt0", cnt0, 1);

    // Counter wrap on ch1
    do_reset();
    wrap_exp[0] = 2'd1;
    wrap_exp[1] = 2'd2;
    wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0;
    wrap_exp[4] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      send(8'hC0 + 8'(i), 1'b1, 1'b1, 1, w);
      @(posedge clk);
      #1;
      chk($sformatf("wrap_cnt1_%0d", i), cnt1, wrap_exp[i]);
    end
    chk("wrap_cnt0", cnt0, 0);

    // Reset mid-packet with out1 holding a beat
    do_reset();
    out1_ready = 1'b0;
    send(8'hD1, 1'b0, 1'b1, 1, w);
    chk("mid_out1_valid", out1_valid, 1);
    #2;
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("mid_async_valid", out1_valid, 0);
    chk("mid_async_data", out1_data, 0);
    chk("mid_async_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out1_ready = 1'b1;
    send(8'hE1, 1'b1, 1'b0, 0, w);
    chk("mid_reroute_out0", out0_valid, 1);
    chk("mid_reroute_out1", out1_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_cnts", {cnt1, cnt0}, {2'd0, 2'd1});

    repeat (3) @(posedge clk);
    #1;
    chk("final_q0", q0.size(), 0);
    chk("final_q1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
